mem_port_arb: RTL and testbench
===============================

// Module: mem_port_arb
// PURPOSE
//  Shares one single-port memory between instruction fetch (IF) and the load/store/swap data path (D).
//  Sequences every access through ISSUE, WAIT and RESP, because memory read data returns MEM_LAT cycles after issue.
//  Sits between the SISC control FSM / datapath and the unified memory.
//  ctrl holds a requester in its current state until that requester's ack.
// PARAMETERS
//  AW       16  address width
//  DW       32  data width
//  MEM_LAT  2   cycles from mem_en to valid mem_rdata; legal range 1..4
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst_f      in   1   synchronous reset, active-low
//  halt       in   1   high = issue no new grants (from ctrl on HLT)
//  if_req     in   1   fetch request (read only)
//  if_addr    in   AW  fetch address
//  if_gnt     out  1   1-cycle pulse: IF request accepted
//  if_ack     out  1   1-cycle pulse: if_rdata valid
//  if_rdata   out  DW  fetched word
//  d_req      in   1   data request
//  d_we       in   1   1 = write, 0 = read
//  d_addr     in   AW  data address
//  d_wdata    in   DW  write data
//  d_gnt      out  1   1-cycle pulse: D request accepted
//  d_ack      out  1   1-cycle pulse: access done; d_rdata valid if read
//  d_rdata    out  DW  loaded word
//  mem_en     out  1   memory access strobe, 1 cycle per access
//  mem_we     out  1   memory write enable, qualified by mem_en
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1   high whenever state != IDLE
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset: when rst_f=0 at posedge:
//    - state goes to IDLE; in-flight access is abandoned with no ack.
//    - All outputs become 0; the wait counter is cleared.
//    - last_gnt becomes IF, so D wins the first tie.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. RESP always returns to IDLE; there are no back-to-back issues.
//  - IDLE: if halt=0 and any req=1, latch the winner and its addr/we/wdata, then go to ISSUE.
//    - IF requests are latched with we=0.
//    - Winner, only one req: that requester.
//    - Winner, both reqs: the requester other than last_gnt; last_gnt is updated to the winner.
//    - If halt=1 or no req, stay in IDLE.
//  - ISSUE (1 cycle):
//    - Winner's gnt=1.
//    - mem_en=1; mem_we/mem_addr/mem_wdata carry the latched values.
//    - Load counter with MEM_LAT-1, then go to WAIT.
//  - WAIT (MEM_LAT cycles):
//    - mem_en=0 and mem_we=0. mem_addr/mem_wdata are don't-care.
//    - On the final WAIT cycle (counter==0), capture mem_rdata into the winner's rdata register if the access is a read, then go to RESP.
//  - RESP (1 cycle): winner's ack=1, then go to IDLE.
//  - Latency: req sampled in IDLE at cycle T -> gnt at T+1 -> ack at T+MEM_LAT+2.
//  - The loser's req stays pending. The loser is granted in the next IDLE cycle (halt permitting).
//  - Requester contract:
//    - Hold req/addr/we/wdata stable until gnt; drop or re-present req after gnt.
//    - A new req is sampled no earlier than the IDLE after its ack.
//    - req high in RESP is accepted in the following IDLE.
//  - halt affects IDLE only. An access already past IDLE completes, acks, and then the block parks in IDLE.
//  - rdata registers hold their value until the next read completes for that port; a write does not disturb d_rdata.
//  - Simultaneous events:
//    - rst_f low overrides halt and req.
//    - req deassert in the same cycle as gnt is legal.
//  - gnt, ack and mem_en are never high for both ports in the same cycle.
// TESTING
//  1. MEM_LAT=2, IF read 0x0010, mem returns 0xDEADBEEF -> if_gnt at T+1; mem_en high exactly 1 cycle; if_ack with if_rdata=0xDEADBEEF at T+4.
//  2. D write addr 0x0020 data 0x12345678 -> at T+1 mem_en=1, mem_we=1, mem_addr=0x0020, mem_wdata=0x12345678; d_ack at T+4; d_rdata unchanged; no IF pulses.
//  3. if_req and d_req held high after reset -> grant order D,I,D,I...; 8 transactions split 4/4; only one mem_en per transaction.
//  4. rst_f=0 during WAIT of a D read -> all outputs 0 next cycle; no d_ack ever; after release with both reqs -> D granted first.
//  5. halt=1 with IF req pending -> no gnt and busy=0; halt=1 raised in WAIT -> current ack still issued, then no gnt until halt=0.
//  6. MEM_LAT sweep 1 and 4, single read -> ack at T+3 and T+6 respectively, with correct rdata.

Source files
------------

// File: rtl/mem_port_arb.sv
// Arbitrates one single-port memory between instruction fetch (IF) and the data path (D).
// Latency: req sampled in IDLE at T -> gnt at T+1 -> ack at T+MEM_LAT+2; one access in flight at a time.
// Backpressure: req is held by the requester until gnt; halt (IDLE only) or a busy FSM leaves req pending.
//
// Ports: clk/rst_f (sync, active-low); halt; IF side if_req/if_addr -> if_gnt/if_ack/if_rdata;
//        D side d_req/d_we/d_addr/d_wdata -> d_gnt/d_ack/d_rdata;
//        memory side mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata; busy = FSM not in IDLE.
module mem_port_arb #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // MEM_LAT is 1..4, so the WAIT countdown (MEM_LAT-1 .. 0) fits in 2 bits.
  localparam int            CW       = 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            win_d_q, win_d_d;     // 1 = current access belongs to D
  logic            last_d_q, last_d_d;   // 1 = last tie went to D
  logic            we_q, we_d;
  logic            pick_d;
  logic            if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic            if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic            mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d_d     = win_d_q;
    last_d_d    = last_d_q;
    we_d        = we_q;
    pick_d      = 1'b0;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    // The address/data registers double as the latch for the winner's request.
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (!halt && (if_req || d_req)) begin
          // On a tie the port that did not win the previous tie goes first.
          pick_d  = d_req && (!if_req || !last_d_q);
          win_d_d = pick_d;
          if (if_req && d_req) last_d_d = pick_d;
          we_d        = pick_d ? d_we : 1'b0;
          mem_addr_d  = pick_d ? d_addr : if_addr;
          mem_wdata_d = pick_d ? d_wdata : '0;
          // Outputs below are what the ISSUE cycle shows.
          if_gnt_d = !pick_d;
          d_gnt_d  = pick_d;
          mem_en_d = 1'b1;
          mem_we_d = pick_d ? d_we : 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (win_d_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          if_ack_d = !win_d_q;
          d_ack_d  = win_d_q;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      win_d_q     <= 1'b0;
      last_d_q    <= 1'b0;
      we_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_d_q     <= win_d_d;
      last_d_q    <= last_d_d;
      we_q        <= we_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: three instances (MEM_LAT 2, 1, 4) share the same requester stimulus.
// Each instance has its own memory model returning data exactly MEM_LAT cycles after mem_en.
// Expected gnt/ack events are queued per instance when stimulus is driven and popped on each DUT pulse.
module tb_mem_port_arb;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_f, halt, if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;

  logic          if_gnt_w[NI], if_ack_w[NI], d_gnt_w[NI], d_ack_w[NI];
  logic          mem_en_w[NI], mem_we_w[NI], busy_w[NI];
  logic [DW-1:0] if_rdata_w[NI], d_rdata_w[NI], mem_wdata_w[NI], mem_rdata_w[NI];
  logic [AW-1:0] mem_addr_w[NI];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {a, ~a};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic [3:0]    pv;
    logic [AW-1:0] pa [4];

    mem_port_arb #(.AW(AW), .DW(DW), .MEM_LAT(L)) u_dut (
      .clk(clk), .rst_f(rst_f), .halt(halt),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[g]), .if_ack(if_ack_w[g]),
      .if_rdata(if_rdata_w[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_w[g]), .d_ack(d_ack_w[g]), .d_rdata(d_rdata_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata_w[g]), .busy(busy_w[g])
    );

    always @(posedge clk) begin
      if (!rst_f) pv <= '0;
      else        pv <= {pv[2:0], mem_en_w[g] & ~mem_we_w[g]};
      pa[0] <= mem_addr_w[g];
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end
    // Data is only valid in the single cycle MEM_LAT after mem_en; otherwise garbage.
    assign mem_rdata_w[g] = pv[L-1] ? rom(pa[L-1]) : 32'hBAD0BAD0;
  end

  typedef struct {
    logic          is_ack;
    logic          is_d;
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } ev_t;

  typedef struct {
    logic          is_d;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  ev_t  sb [NI][$];
  vec_t tbl [7];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  int   if_gcnt [NI];
  int   d_gcnt [NI];

  task automatic chk(input string name, input int inst, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] outs(input int i);
    logic [127:0] v;
    v = '0;
    v[118:0] = {if_gnt_w[i], if_ack_w[i], if_rdata_w[i], d_gnt_w[i], d_ack_w[i], d_rdata_w[i],
                mem_en_w[i], mem_we_w[i], mem_addr_w[i], mem_wdata_w[i], busy_w[i]};
    return v;
  endfunction

  // Request sampled in IDLE at cycle s: gnt at s+1, ack at s+MEM_LAT+2.
  task automatic push_txn(input int i, input int s, input logic is_d, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rd);
    ev_t e;
    e.is_ack = 1'b0; e.is_d = is_d; e.cyc = s + 1; e.we = we; e.addr = addr; e.dat = wdata;
    sb[i].push_back(e);
    e.is_ack = 1'b1; e.cyc = s + lat_of(i) + 2; e.dat = exp_rd;
    sb[i].push_back(e);
  endtask

  task automatic push_all(input int s, input logic is_d, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] exp_rd);
    for (int i = 0; i < NI; i++) push_txn(i, s, is_d, we, addr, wdata, exp_rd);
  endtask

  task automatic monitor();
    ev_t  e;
    logic gi, gd, ai, ad;
    for (int i = 0; i < NI; i++) begin
      gi = if_gnt_w[i]; gd = d_gnt_w[i]; ai = if_ack_w[i]; ad = d_ack_w[i];
      if (gi | gd | ai | ad | mem_en_w[i]) begin
        chk("one_pulse_per_cycle", i, 128'((gi & gd) | (ai & ad) | ((gi | gd) & (ai | ad))), 128'(0));
        chk("mem_en_with_gnt", i, 128'(mem_en_w[i]), 128'(gi | gd));
      end
      if (gi | gd | ai | ad) begin
        if (sb[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse inst%0d cycle %0d: got gnt=%b%b ack=%b%b expected none",
                   i, cyc, gi, gd, ai, ad);
        end else begin
          e = sb[i].pop_front();
          chk("event_kind", i, 128'(ai | ad), 128'(e.is_ack));
          chk("event_port", i, 128'(gd | ad), 128'(e.is_d));
          chk("event_cycle", i, 128'(cyc), 128'(e.cyc));
          if (gi | gd) begin
            if (gi) if_gcnt[i]++;
            if (gd) d_gcnt[i]++;
            chk("mem_we", i, 128'(mem_we_w[i]), 128'(e.we));
            chk("mem_addr", i, 128'(mem_addr_w[i]), 128'(e.addr));
            if (e.we) chk("mem_wdata", i, 128'(mem_wdata_w[i]), 128'(e.dat));
            chk("busy_at_gnt", i, 128'(busy_w[i]), 128'(1));
          end else begin
            chk("rdata", i, 128'(e.is_d ? d_rdata_w[i] : if_rdata_w[i]), 128'(e.dat));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_on) monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic expect_empty(input string name);
    for (int i = 0; i < NI; i++) begin
      chk(name, i, 128'(sb[i].size()), 128'(0));
      sb[i].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t, s, p, n;
    logic isd;

    tbl[0] = '{1'b0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 16'h0020, 32'h12345678, 32'h00000000};
    tbl[2] = '{1'b1, 1'b0, 16'h0030, 32'h0,        32'h0030FFCF};
    tbl[3] = '{1'b1, 1'b1, 16'hFFFF, 32'hA5A5A5A5, 32'h0030FFCF};
    tbl[4] = '{1'b0, 1'b0, 16'hFFFF, 32'h0,        32'hFFFF0000};
    tbl[5] = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'h0000FFFF};
    tbl[6] = '{1'b0, 1'b0, 16'h1234, 32'h0,        32'h1234EDCB};

    rst_f = 1'b0; halt = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < NI; i++) begin if_gcnt[i] = 0; d_gcnt[i] = 0; end
    tick();
    tick();
    for (int i = 0; i < NI; i++) chk("reset_outputs", i, outs(i), 128'(0));
    rst_f = 1'b1;
    mon_on = 1'b1;
    tick();

    // Single transactions, one requester at a time.
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].is_d) begin
        d_req = 1'b1; d_we = tbl[v].we; d_addr = tbl[v].addr; d_wdata = tbl[v].wdata;
      end else begin
        if_req = 1'b1; if_addr = tbl[v].addr;
      end
      push_all(cyc, tbl[v].is_d, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].exp_rd);
      tick();
      if_req = 1'b0; d_req = 1'b0;
      repeat (7) tick();
      expect_empty("vector_drained");
    end

    // Both requests held: D first after reset, then strict alternation.
    rst_f = 1'b0;
    tick();
    rst_f = 1'b1;
    tick();
    t = cyc;
    if_req = 1'b1; if_addr = 16'h0050;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
    for (int i = 0; i < NI; i++) begin
      if_gcnt[i] = 0; d_gcnt[i] = 0;
      p = lat_of(i) + 3;
      n = 35 / p + 1;
      for (int k = 0; k < n; k++) begin
        isd = (k % 2 == 0);
        push_txn(i, t + k * p, isd, 1'b0, isd ? 16'h0040 : 16'h0050, '0,
                 rom(isd ? 16'h0040 : 16'h0050));
      end
    end
    repeat (36) tick();
    if_req = 1'b0; d_req = 1'b0;
    repeat (12) tick();
    expect_empty("alternation_drained");
    chk("d_grant_count", 0, 128'(d_gcnt[0]), 128'(4));
    chk("if_grant_count", 0, 128'(if_gcnt[0]), 128'(4));

    // Reset during WAIT of a D read: abandoned, then D wins the first tie.
    t = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
    push_all(t, 1'b1, 1'b0, 16'h0060, '0, rom(16'h0060));
    tick();
    d_req = 1'b0;
    tick();
    rst_f = 1'b0;
    for (int i = 0; i < NI; i++) sb[i].delete();
    tick();
    for (int i = 0; i < NI; i++) chk("reset_in_wait_outputs", i, outs(i), 128'(0));
    rst_f = 1'b1;
    d_req = 1'b1; d_addr = 16'h0070;
    if_req = 1'b1; if_addr = 16'h0080;
    s = cyc;
    for (int i = 0; i < NI; i++) begin
      push_txn(i, s, 1'b1, 1'b0, 16'h0070, '0, rom(16'h0070));
      push_txn(i, s + lat_of(i) + 3, 1'b0, 1'b0, 16'h0080, '0, rom(16'h0080));
    end
    tick();
    d_req = 1'b0;
    repeat (7) tick();
    if_req = 1'b0;
    repeat (12) tick();
    expect_empty("post_reset_drained");

    // halt with IF pending: nothing granted, busy low.
    if_req = 1'b1; if_addr = 16'h0090; halt = 1'b1;
    repeat (5) begin
      tick();
      for (int i = 0; i < NI; i++) chk("halt_idle_busy", i, 128'(busy_w[i]), 128'(0));
    end
    halt = 1'b0;
    push_all(cyc, 1'b0, 1'b0, 16'h0090, '0, rom(16'h0090));
    tick();
    if_req = 1'b0;
    tick();
    // halt raised while the IF access is in WAIT; its ack must still arrive.
    halt = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00A0; d_wdata = 32'hCAFEF00D;
    repeat (12) tick();
    for (int i = 0; i < NI; i++) chk("halt_parked_busy", i, 128'(busy_w[i]), 128'(0));
    expect_empty("halt_inflight_drained");
    halt = 1'b0;
    push_all(cyc, 1'b1, 1'b1, 16'h00A0, 32'hCAFEF00D, rom(16'h0070));
    tick();
    d_req = 1'b0;
    repeat (8) tick();
    expect_empty("halt_release_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
